// File: rtl/lpif_rx_align_pkg.sv
// Shared types and constants for the LPIF x1 asym1 receive deskew / strobe-lock slice.
package lpif_rx_align_pkg;

    localparam int unsigned CH_WIDTH  = 40;
    localparam int unsigned STB_LOC   = 1;
    localparam int unsigned MRK_LOC   = 39;
    localparam int unsigned PAYLOAD_W = 42;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

endpackage

// File: rtl/lpif_rx_chan_delay.sv
// Per-channel tapped delay line: tap 0 is the live input, tap k is the input k cycles ago.
module lpif_rx_chan_delay
    import lpif_rx_align_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned SEL_W = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [CH_WIDTH-1:0] din_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic [CH_WIDTH-1:0] dout_o
);

    logic [CH_WIDTH-1:0] tap_q [1:DEPTH];

    // Shift the channel word down the delay line every cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 1; i <= DEPTH; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            tap_q[1] <= din_i;
            for (int unsigned i = 2; i <= DEPTH; i++) begin
                tap_q[i] <= tap_q[i-1];
            end
        end
    end

    // Select the requested tap; tap 0 bypasses the registers.
    always_comb begin
        dout_o = din_i;
        for (int unsigned i = 1; i <= DEPTH; i++) begin
            if (sel_i == SEL_W'(i)) begin
                dout_o = tap_q[i];
            end
        end
    end

endmodule

// File: rtl/lpif_rx_x1_asym1_strobe_align.sv
// Receive channel deskew and strobe lock for the x1 asym1 full-rate LPIF link.
// Finds the strobe on each PHY channel, delays the early channel to line both up,
// verifies LOCK_CNT coincident strobes, then emits the unpacked 42-bit word.
// Optional: define LPIF_RX_MARKER_CHECK_EN to also require matching aligned markers
// while verifying/locked.
module lpif_rx_x1_asym1_strobe_align
    import lpif_rx_align_pkg::*;
#(
    parameter int unsigned MAX_SKEW = 3,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic                          clk_rd,
    input  logic                          rst_rd_n,
    input  logic                          rx_align_en,
    input  logic [CH_WIDTH-1:0]           rx_phy0,
    input  logic [CH_WIDTH-1:0]           rx_phy1,
    output logic [PAYLOAD_W-1:0]          rx_downstream_data,
    output logic                          rx_downstream_valid,
    output logic                          rx_align_locked,
    output logic                          rx_align_err,
    output logic                          rx_skew_ch,
    output logic [$clog2(MAX_SKEW+1)-1:0] rx_skew_cyc
);

    localparam int unsigned SKW = $clog2(MAX_SKEW + 1);
    localparam int unsigned GW  = $clog2(LOCK_CNT + 1);

    align_state_e         state_q, state_d;
    logic                 wait_q, wait_d;
    logic                 first_q, first_d;
    logic [SKW-1:0]       win_q, win_d;
    logic [GW-1:0]        good_q, good_d;
    logic                 skew_ch_q, skew_ch_d;
    logic [SKW-1:0]       skew_cyc_q, skew_cyc_d;
    logic                 err_q, err_d;
    logic [PAYLOAD_W-1:0] data_q, data_d;

    logic [SKW-1:0]      sel0, sel1;
    logic [CH_WIDTH-1:0] a0, a1;
    logic                stb0, stb1, a0_stb, a1_stb, aln_bad;
    logic                unused_bits;

    assign sel0 = skew_ch_q ? '0 : skew_cyc_q;
    assign sel1 = skew_ch_q ? skew_cyc_q : '0;

    lpif_rx_chan_delay #(
        .DEPTH (MAX_SKEW),
        .SEL_W (SKW)
    ) u_dly0 (
        .clk_i   (clk_rd),
        .rst_n_i (rst_rd_n),
        .din_i   (rx_phy0),
        .sel_i   (sel0),
        .dout_o  (a0)
    );

    lpif_rx_chan_delay #(
        .DEPTH (MAX_SKEW),
        .SEL_W (SKW)
    ) u_dly1 (
        .clk_i   (clk_rd),
        .rst_n_i (rst_rd_n),
        .din_i   (rx_phy1),
        .sel_i   (sel1),
        .dout_o  (a1)
    );

    assign stb0   = rx_phy0[STB_LOC];
    assign stb1   = rx_phy1[STB_LOC];
    assign a0_stb = a0[STB_LOC];
    assign a1_stb = a1[STB_LOC];

`ifdef LPIF_RX_MARKER_CHECK_EN
    assign aln_bad = (a0_stb ^ a1_stb) | (a0[MRK_LOC] ^ a1[MRK_LOC]);
`else
    assign aln_bad = a0_stb ^ a1_stb;
`endif

    // Strobes, markers and the upper ch1 bits carry no payload.
    assign unused_bits = ^{a0[MRK_LOC], a1[CH_WIDTH-1:5], a1[STB_LOC]};

    // State and datapath registers.
    always_ff @(posedge clk_rd or negedge rst_rd_n) begin
        if (!rst_rd_n) begin
            state_q    <= HUNT;
            wait_q     <= 1'b0;
            first_q    <= 1'b0;
            win_q      <= '0;
            good_q     <= '0;
            skew_ch_q  <= 1'b0;
            skew_cyc_q <= '0;
            err_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            first_q    <= first_d;
            win_q      <= win_d;
            good_q     <= good_d;
            skew_ch_q  <= skew_ch_d;
            skew_cyc_q <= skew_cyc_d;
            err_q      <= err_d;
            data_q     <= data_d;
        end
    end

    // Hunt/verify/lock next-state logic and payload unpacking.
    // win_q holds the distance k from the first strobe during the current cycle,
    // so the timeout fires on the cycle where k == MAX_SKEW and the partner is absent.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        first_d    = first_q;
        win_d      = win_q;
        good_d     = good_q;
        skew_ch_d  = skew_ch_q;
        skew_cyc_d = skew_cyc_q;
        err_d      = 1'b0;
        data_d     = rx_align_en ? {a1[4:2], a1[0], a0[38:2], a0[0]} : '0;

        if (!rx_align_en) begin
            state_d    = HUNT;
            wait_d     = 1'b0;
            win_d      = '0;
            good_d     = '0;
            skew_ch_d  = 1'b0;
            skew_cyc_d = '0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (wait_q) begin
                        if (first_q ? stb0 : stb1) begin
                            skew_ch_d  = first_q;
                            skew_cyc_d = win_q;
                            wait_d     = 1'b0;
                            win_d      = '0;
                            good_d     = GW'(1);
                            state_d    = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                        end else if (first_q ? stb1 : stb0) begin
                            win_d = SKW'(1);
                        end else if (win_q == SKW'(MAX_SKEW)) begin
                            err_d  = 1'b1;
                            wait_d = 1'b0;
                            win_d  = '0;
                        end else begin
                            win_d = win_q + SKW'(1);
                        end
                    end else if (stb0 && stb1) begin
                        skew_ch_d  = 1'b0;
                        skew_cyc_d = '0;
                        good_d     = GW'(1);
                        state_d    = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    end else if (stb0 || stb1) begin
                        wait_d  = 1'b1;
                        first_d = stb1;
                        win_d   = SKW'(1);
                    end
                end
                VERIFY, LOCKED: begin
                    if (aln_bad) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                        good_d  = '0;
                        if (state_q == VERIFY) begin
                            skew_ch_d  = 1'b0;
                            skew_cyc_d = '0;
                        end
                    end else if (a0_stb && a1_stb && (state_q == VERIFY)) begin
                        if (good_q != GW'(LOCK_CNT)) begin
                            good_d = good_q + GW'(1);
                        end
                        if (good_q + GW'(1) == GW'(LOCK_CNT)) begin
                            state_d = LOCKED;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign rx_align_locked     = (state_q == LOCKED);
    assign rx_downstream_valid = (state_q == LOCKED);
    assign rx_align_err        = err_q;
    assign rx_skew_ch          = skew_ch_q;
    assign rx_skew_cyc         = skew_cyc_q;
    assign rx_downstream_data  = data_q;

endmodule

// File: tb/tb_lpif_rx_x1_asym1_strobe_align.sv
// Self-checking bench for lpif_rx_x1_asym1_strobe_align (MAX_SKEW=3, LOCK_CNT=4).
module tb_lpif_rx_x1_asym1_strobe_align;

    localparam int unsigned MAX_SKEW = 3;
    localparam int unsigned LOCK_CNT = 4;
`ifdef LPIF_RX_MARKER_CHECK_EN
    localparam logic MRK_EN = 1'b1;
`else
    localparam logic MRK_EN = 1'b0;
`endif
    localparam logic [39:0] STB = 40'h2;

    logic        clk_rd = 1'b0;
    logic        rst_rd_n;
    logic        rx_align_en;
    logic [39:0] rx_phy0, rx_phy1;
    logic [41:0] rx_downstream_data;
    logic        rx_downstream_valid, rx_align_locked, rx_align_err, rx_skew_ch;
    logic [1:0]  rx_skew_cyc;

    typedef struct {
        logic [39:0] p0;
        logic [39:0] p1;
        logic        lk;
        logic [41:0] dt;
    } vec_t;

    typedef struct {
        logic        lk;
        logic        er;
        logic [41:0] dt;
    } exp_t;

    vec_t tbl [32];
    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;

    lpif_rx_x1_asym1_strobe_align #(
        .MAX_SKEW (MAX_SKEW),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk_rd              (clk_rd),
        .rst_rd_n            (rst_rd_n),
        .rx_align_en         (rx_align_en),
        .rx_phy0             (rx_phy0),
        .rx_phy1             (rx_phy1),
        .rx_downstream_data  (rx_downstream_data),
        .rx_downstream_valid (rx_downstream_valid),
        .rx_align_locked     (rx_align_locked),
        .rx_align_err        (rx_align_err),
        .rx_skew_ch          (rx_skew_ch),
        .rx_skew_cyc         (rx_skew_cyc)
    );

    always #5 clk_rd = ~clk_rd;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [41:0] pack(input logic [39:0] w0, input logic [39:0] w1);
        pack = {w1[4:2], w1[0], w0[38:2], w0[0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input logic [39:0] p0, input logic [39:0] p1, input logic en,
                        input logic lk, input logic er, input logic [41:0] dt);
        exp_t e;
        exp_t got;
        rx_phy0     = p0;
        rx_phy1     = p1;
        rx_align_en = en;
        e.lk = lk;
        e.er = er;
        e.dt = dt;
        sb.push_back(e);
        @(posedge clk_rd);
        #1;
        got = sb.pop_front();
        chk("locked", 64'(rx_align_locked), 64'(got.lk));
        chk("valid", 64'(rx_downstream_valid), 64'(got.lk));
        chk("err", 64'(rx_align_err), 64'(got.er));
        chk("data", 64'(rx_downstream_data), 64'(got.dt));
    endtask

    task automatic idle(input int n, input logic lk);
        for (int i = 0; i < n; i++) step('0, '0, 1'b1, lk, 1'b0, '0);
    endtask

    task automatic zero_skew_lock();
        for (int k = 0; k < 4; k++) begin
            step(STB, STB, 1'b1, (k == 3), 1'b0, '0);
            idle(7, (k == 3));
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_locked"}, 64'(rx_align_locked), 64'(0));
        chk({nm, "_valid"}, 64'(rx_downstream_valid), 64'(0));
        chk({nm, "_err"}, 64'(rx_align_err), 64'(0));
        chk({nm, "_data"}, 64'(rx_downstream_data), 64'(0));
        chk({nm, "_skew_ch"}, 64'(rx_skew_ch), 64'(0));
        chk({nm, "_skew_cyc"}, 64'(rx_skew_cyc), 64'(0));
    endtask

    initial begin
        logic [39:0] w0, w1;

        for (int i = 0; i < 32; i++) begin
            w0 = {8'($urandom()), 32'($urandom())};
            w1 = {8'($urandom()), 32'($urandom())};
            w0[1]  = (i % 8 == 0);
            w1[1]  = (i % 8 == 0);
            w0[39] = 1'b0;
            w1[39] = 1'b0;
            if (i == 25) begin
                w0 = 40'h00_0000_0005;
                w1 = '0;
            end
            tbl[i].p0 = w0;
            tbl[i].p1 = w1;
            tbl[i].lk = (i >= 24);
            tbl[i].dt = pack(w0, w1);
        end

        rst_rd_n    = 1'b0;
        rx_align_en = 1'b0;
        rx_phy0     = '0;
        rx_phy1     = '0;
        #12;
        chk_all_zero("reset");
        rst_rd_n = 1'b1;

        // Zero skew: coincident strobes every 8 cycles, lock after the 4th pair.
        for (int i = 0; i < 32; i++) begin
            step(tbl[i].p0, tbl[i].p1, 1'b1, tbl[i].lk, 1'b0, tbl[i].dt);
            if (i == 24) chk("zs_skew_cyc", 64'(rx_skew_cyc), 64'(0));
            if (i == 25) chk("zs_data_lsb", 64'(rx_downstream_data[1:0]), 64'(2'b11));
        end

        // Lone ch1 strobe while locked, then relock.
        step('0, STB, 1'b1, 1'b0, 1'b1, '0);
        step('0, '0, 1'b1, 1'b0, 1'b0, '0);
        idle(2, 1'b0);
        zero_skew_lock();

        // Skew 2, ch0 early.
        step('0, '0, 1'b0, 1'b0, 1'b0, '0);
        step(STB, '0, 1'b1, 1'b0, 1'b0, '0);
        idle(1, 1'b0);
        step('0, STB, 1'b1, 1'b0, 1'b0, '0);
        chk("s2_skew_ch", 64'(rx_skew_ch), 64'(0));
        chk("s2_skew_cyc", 64'(rx_skew_cyc), 64'(2));
        for (int k = 1; k <= 3; k++) begin
            idle(5, 1'b0);
            step(STB, '0, 1'b1, 1'b0, 1'b0, '0);
            idle(1, 1'b0);
            step('0, STB, 1'b1, (k == 3), 1'b0, '0);
        end
        step(40'h00_0000_0001, '0, 1'b1, 1'b1, 1'b0, '0);
        step('0, '0, 1'b1, 1'b1, 1'b0, '0);
        step('0, 40'h14, 1'b1, 1'b1, 1'b0, 42'h280_0000_0001);

        // Enable dropped while locked with nonzero skew.
        step('0, '0, 1'b0, 1'b0, 1'b0, '0);
        chk("en_skew_ch", 64'(rx_skew_ch), 64'(0));
        chk("en_skew_cyc", 64'(rx_skew_cyc), 64'(0));

        // Async reset while in VERIFY with skew 2.
        step(STB, '0, 1'b1, 1'b0, 1'b0, '0);
        idle(1, 1'b0);
        step('0, STB, 1'b1, 1'b0, 1'b0, '0);
        step(40'h1C, 40'h14, 1'b1, 1'b0, 1'b0, pack('0, 40'h14));
        chk("pre_rst_skew_cyc", 64'(rx_skew_cyc), 64'(2));
        rx_phy0 = '0;
        rx_phy1 = '0;
        #2 rst_rd_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk_rd);
        #1;
        rst_rd_n = 1'b1;
        idle(2, 1'b0);
        zero_skew_lock();

        // Skew 4 exceeds MAX_SKEW: timeout error, no lock.
        step('0, '0, 1'b0, 1'b0, 1'b0, '0);
        step('0, STB, 1'b1, 1'b0, 1'b0, '0);
        idle(2, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b1, '0);
        step('0, '0, 1'b1, 1'b0, 1'b0, '0);
        chk("to_skew_cyc", 64'(rx_skew_cyc), 64'(0));

        // Skew exactly MAX_SKEW, ch1 early, then lock.
        idle(2, 1'b0);
        step('0, STB, 1'b1, 1'b0, 1'b0, '0);
        idle(2, 1'b0);
        step(STB, '0, 1'b1, 1'b0, 1'b0, '0);
        chk("s3_skew_ch", 64'(rx_skew_ch), 64'(1));
        chk("s3_skew_cyc", 64'(rx_skew_cyc), 64'(3));
        for (int k = 1; k <= 3; k++) begin
            idle(4, 1'b0);
            step('0, STB, 1'b1, 1'b0, 1'b0, '0);
            idle(2, 1'b0);
            step(STB, '0, 1'b1, (k == 3), 1'b0, '0);
        end

        // Marker mismatch on the aligned pair.
        step(40'h80_0000_0000, '0, 1'b1, !MRK_EN, MRK_EN, '0);
        step('0, '0, 1'b1, !MRK_EN, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
